// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause field
// positions and reset constants used by cp0_ctrl and its timer.
package cp0_pkg;

  typedef enum logic [4:0] {
    CP0_BADVADDR = 5'd8,
    CP0_COUNT    = 5'd9,
    CP0_COMPARE  = 5'd11,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14,
    CP0_PRID     = 5'd15,
    CP0_CONFIG   = 5'd16
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int STATUS_IE_BIT   = 0;
  localparam int STATUS_EXL_BIT  = 1;
  localparam int STATUS_IM_LO    = 8;
  localparam int STATUS_BEV_BIT  = 22;
  localparam int CAUSE_EXC_LO    = 2;
  localparam int CAUSE_IP_LO     = 8;
  localparam int CAUSE_BD_BIT    = 31;

  localparam logic [31:0] STATUS_RST = 32'h0040_0000;
  localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

  function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl,
                                              input logic ie);
    logic [31:0] s;
    s = STATUS_RST;
    s[STATUS_IM_LO +: 8]  = im;
    s[STATUS_EXL_BIT]     = exl;
    s[STATUS_IE_BIT]      = ie;
    return s;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [7:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] c;
    c = '0;
    c[CAUSE_BD_BIT]       = bd;
    c[CAUSE_IP_LO +: 8]   = ip;
    c[CAUSE_EXC_LO +: 5]  = exc_code;
    return c;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled free-running Count, Compare match flag.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  localparam logic [3:0] PRESC_MAX = 4'(COUNT_DIV - 1);

  logic [3:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q, timer_d;
  logic        tick;

  // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    presc_d   = presc_q + 4'd1;
    tick      = 1'b0;
    compare_d = compare_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      tick    = 1'b1;
    end
    count_d = tick ? count_q + 32'd1 : count_q;
    timer_d = timer_q | (count_q == compare_q);
    // Software writes override the same-cycle increment / match.
    if (count_we) begin
      count_d = wdata;
      presc_d = '0;
    end
    if (compare_we) begin
      compare_d = wdata;
      timer_d   = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments; rst is synchronous active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_ctrl.sv
// MIPS-style CP0 control block: Status/Cause/EPC/BadVAddr, exception and ERET
// handling, interrupt pending. Define CP0_TIMER_EN to include Count/Compare.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_pending_o,
  output logic                  timer_int_o
);

  if (NUM_HW_INT < 1 || NUM_HW_INT > 6) begin : g_bad_num_hw_int
    $error("cp0_ctrl: NUM_HW_INT must be 1..6");
  end
  if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_count_div
    $error("cp0_ctrl: COUNT_DIV must be 1..16");
  end

  logic we_ok, exc_ok, eret_ok;
  assign we_ok   = we & ~stall;
  assign exc_ok  = exc_valid & ~stall;
  assign eret_ok = eret & ~stall;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic [31:0] count, compare;
  logic        timer_int;

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .count_we    (we_ok && (waddr == CP0_COUNT)),
    .compare_we  (we_ok && (waddr == CP0_COMPARE)),
    .wdata       (wdata),
    .count_o     (count),
    .compare_o   (compare),
    .timer_int_o (timer_int)
  );
`else
  assign count     = '0;
  assign compare   = '0;
  assign timer_int = 1'b0;
`endif

  logic [7:0] ip;
  assign ip = {ip_hw_q[5] | timer_int, ip_hw_q[4:0], ip_sw_q};

  // Field updates are ordered we, then eret, then exception so later ones win.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = 6'(hw_int);
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (we_ok) begin
      case (waddr)
        CP0_STATUS: begin
          im_d  = wdata[STATUS_IM_LO +: 8];
          exl_d = wdata[STATUS_EXL_BIT];
          ie_d  = wdata[STATUS_IE_BIT];
        end
        CP0_CAUSE: ip_sw_d = wdata[CAUSE_IP_LO +: 2];
        CP0_EPC:   epc_d   = wdata;
        default: ;
      endcase
    end

    if (eret_ok) exl_d = 1'b0;

    if (exc_ok) begin
      // A nested exception (EXL already set) keeps the original return point.
      if (!exl_q) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end else begin
        epc_d = epc_q;
      end
      exc_code_d = exc_code;
      exl_d      = 1'b1;
      if (exc_code == EXC_ADEL || exc_code == EXC_ADES) badvaddr_d = exc_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q       <= STATUS_RST[STATUS_IM_LO +: 8];
      exl_q      <= STATUS_RST[STATUS_EXL_BIT];
      ie_q       <= STATUS_RST[STATUS_IE_BIT];
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign status_o      = pack_status(im_q, exl_q, ie_q);
  assign cause_o       = pack_cause(bd_q, ip, exc_code_q);
  assign epc_o         = epc_q;
  assign timer_int_o   = timer_int;
  assign int_pending_o = ie_q & ~exl_q & |(ip & im_q);

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_o;
      CP0_CAUSE:    rdata = cause_o;
      CP0_EPC:      rdata = epc_q;
      CP0_PRID:     rdata = PRID_VAL;
      CP0_CONFIG:   rdata = CONFIG_VAL;
      default: ;
    endcase
  end

endmodule
